// File: rtl/perceptron_pkg.sv
// Shared types and defaults for the perceptron weight/bias loader.
// The CHECK state exists only when PERCEPTRON_WB_CHECKSUM_EN is defined.
package perceptron_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N0_DEF     = 6;
    localparam int N1_DEF     = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W0,
        LOAD_W1,
`ifdef PERCEPTRON_WB_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } wb_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Address width for a layer index; never narrower than one bit.
    function automatic int addr_w(input int n0, input int n1);
        return (max2(n0, n1) > 1) ? $clog2(max2(n0, n1)) : 1;
    endfunction

endpackage

// File: rtl/perceptron_wb_idx_cnt.sv
// Word index counter within a layer: clears on load start, wraps to 0 after
// the terminal index so the next layer starts at address 0.
module perceptron_wb_idx_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] idx_o,
    output logic         tc_o
);

    logic [W-1:0] idx_q, idx_d;

    assign idx_o = idx_q;
    assign tc_o  = (idx_q == last_i);

    always_comb begin
        idx_d = idx_q;
        if (clr_i)
            idx_d = '0;
        else if (inc_i)
            idx_d = tc_o ? '0 : idx_q + W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end

endmodule

// File: rtl/perceptron_wb_loader.sv
// Streams layer-0 then layer-1 weight/bias words into the datapath with one
// registered write strobe per word. Optional checksum word: PERCEPTRON_WB_CHECKSUM_EN.
module perceptron_wb_loader
    import perceptron_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N0     = N0_DEF,
    parameter int N1     = N1_DEF,
    localparam int AW    = addr_w(N0, N1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              val_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              rdy_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [1:0]        W1W0b_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam logic [AW-1:0] LAST0 = AW'(N0 - 1);
    localparam logic [AW-1:0] LAST1 = AW'(N1 - 1);

    wb_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [1:0]        en_q, en_d;
    logic              accept;
    logic              cnt_clr, cnt_inc, cnt_tc;
    logic [AW-1:0]     cnt_idx;

`ifdef PERCEPTRON_WB_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
`endif

    perceptron_wb_idx_cnt #(.W(AW)) u_idx (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .last_i ((state_q == LOAD_W1) ? LAST1 : LAST0),
        .idx_o  (cnt_idx),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        rdy_o = 1'b0;
        case (state_q)
            LOAD_W0, LOAD_W1: rdy_o = 1'b1;
`ifdef PERCEPTRON_WB_CHECKSUM_EN
            CHECK:            rdy_o = 1'b1;
`endif
            default:          rdy_o = 1'b0;
        endcase
    end

    assign accept = val_i & rdy_o;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        en_d    = 2'b00;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
`ifdef PERCEPTRON_WB_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD_W0;
                    cnt_clr = 1'b1;
`ifdef PERCEPTRON_WB_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD_W0, LOAD_W1: begin
                if (accept) begin
                    en_d    = (state_q == LOAD_W0) ? 2'b01 : 2'b10;
                    data_d  = data_i;
                    addr_d  = cnt_idx;
                    cnt_inc = 1'b1;
`ifdef PERCEPTRON_WB_CHECKSUM_EN
                    sum_d   = sum_q + data_i;
`endif
                    if (cnt_tc) begin
`ifdef PERCEPTRON_WB_CHECKSUM_EN
                        state_d = (state_q == LOAD_W0) ? LOAD_W1 : CHECK;
`else
                        state_d = (state_q == LOAD_W0) ? LOAD_W1 : DONE;
`endif
                    end
                end
            end
`ifdef PERCEPTRON_WB_CHECKSUM_EN
            // Checksum word is consumed without a strobe.
            CHECK: begin
                if (accept) begin
                    if (data_i != sum_q)
                        err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            en_q    <= 2'b00;
`ifdef PERCEPTRON_WB_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
`ifdef PERCEPTRON_WB_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign wb_data_o  = data_q;
    assign wb_addr_o  = addr_q;
    assign W1W0b_en_o = en_q;
    assign done_o     = (state_q == DONE);
    // Stays high through the last strobe, which lands in DONE when no checksum.
    assign busy_o     = rdy_o | (|en_q);

`ifdef PERCEPTRON_WB_CHECKSUM_EN
    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_perceptron_wb_loader.sv
// Directed self-checking bench for perceptron_wb_loader (default parameters).
// Observed vector: {W1W0b_en_o, wb_addr_o, wb_data_o, busy_o, done_o, rdy_o}.
module tb_perceptron_wb_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic       val_i;
    logic [7:0] data_i;
    logic       rdy_o;
    logic [7:0] wb_data_o;
    logic [2:0] wb_addr_o;
    logic [1:0] W1W0b_en_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    int tests = 0;
    int fails = 0;

    perceptron_wb_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .val_i      (val_i),
        .data_i     (data_i),
        .rdy_o      (rdy_o),
        .wb_data_o  (wb_data_o),
        .wb_addr_o  (wb_addr_o),
        .W1W0b_en_o (W1W0b_en_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] obs();
        return {W1W0b_en_o, wb_addr_o, wb_data_o, busy_o, done_o, rdy_o};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; start_i = 1'b0; val_i = 1'b0; data_i = 8'h00;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        apply_reset();
        tests++;
        if (obs() !== 16'h0000 || error_o !== 1'b0) begin
            fails++; $display("FAIL reset_state got %h err %b want 0000 err 0", obs(), error_o);
        end
    endtask

    task automatic test_nominal();
        logic [15:0] exp;
        apply_reset();
        start_i = 1'b1; cyc(); start_i = 1'b0;
        tests++;
        if (obs() !== {2'b00, 3'd0, 8'h00, 3'b101}) begin
            fails++; $display("FAIL nom_start got %h want %h", obs(), {2'b00, 3'd0, 8'h00, 3'b101});
        end
        for (int k = 0; k < 9; k++) begin
            val_i = 1'b1; data_i = 8'(k + 1); cyc();
`ifdef PERCEPTRON_WB_CHECKSUM_EN
            exp = {(k < 6) ? 2'b01 : 2'b10, (k < 6) ? 3'(k) : 3'(k - 6), 8'(k + 1), 1'b1, 1'b0, 1'b1};
`else
            exp = {(k < 6) ? 2'b01 : 2'b10, (k < 6) ? 3'(k) : 3'(k - 6), 8'(k + 1), 1'b1, k == 8, k < 8};
`endif
            tests++;
            if (obs() !== exp) begin
                fails++; $display("FAIL nom_word%0d got %h want %h", k, obs(), exp);
            end
        end
`ifdef PERCEPTRON_WB_CHECKSUM_EN
        data_i = 8'h2D; cyc();
        tests++;
        if (obs() !== {2'b00, 3'd2, 8'h09, 3'b010}) begin
            fails++; $display("FAIL nom_done got %h want %h", obs(), {2'b00, 3'd2, 8'h09, 3'b010});
        end
`endif
        val_i = 1'b0; cyc();
        tests++;
        if (obs() !== {2'b00, 3'd2, 8'h09, 3'b000} || error_o !== 1'b0) begin
            fails++; $display("FAIL nom_idle got %h err %b want %h err 0", obs(), error_o, {2'b00, 3'd2, 8'h09, 3'b000});
        end
    endtask

    task automatic test_stall();
        logic [0:3]  vp;
        logic [15:0] exp [0:3];
        vp = 4'b1001;
        exp[0] = {2'b01, 3'd0, 8'h11, 3'b101};
        exp[1] = {2'b00, 3'd0, 8'h11, 3'b101};
        exp[2] = {2'b00, 3'd0, 8'h11, 3'b101};
        exp[3] = {2'b01, 3'd1, 8'h44, 3'b101};
        apply_reset();
        start_i = 1'b1; cyc(); start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            val_i = vp[k]; data_i = 8'(8'h11 * (k + 1)); cyc();
            tests++;
            if (obs() !== exp[k]) begin
                fails++; $display("FAIL stall_step%0d got %h want %h", k, obs(), exp[k]);
            end
        end
        val_i = 1'b0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        start_i = 1'b1; cyc(); start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            val_i = 1'b1; data_i = 8'(k + 1); cyc();
        end
        val_i = 1'b0;
        tests++;
        if (obs() !== {2'b01, 3'd3, 8'h04, 3'b101}) begin
            fails++; $display("FAIL mid_4th got %h want %h", obs(), {2'b01, 3'd3, 8'h04, 3'b101});
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (obs() !== 16'h0000 || error_o !== 1'b0) begin
            fails++; $display("FAIL mid_async_rst got %h err %b want 0000 err 0", obs(), error_o);
        end
        cyc(); reset = 1'b0; cyc();
        start_i = 1'b1; cyc(); start_i = 1'b0;
        val_i = 1'b1; data_i = 8'h77; cyc(); val_i = 1'b0;
        tests++;
        if (obs() !== {2'b01, 3'd0, 8'h77, 3'b101}) begin
            fails++; $display("FAIL mid_restart got %h want %h", obs(), {2'b01, 3'd0, 8'h77, 3'b101});
        end
    endtask

    task automatic test_ignored_start();
        apply_reset();
        start_i = 1'b1; cyc(); start_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            val_i = 1'b1; data_i = 8'(k + 1); cyc();
        end
        val_i = 1'b0; start_i = 1'b1; cyc(); start_i = 1'b0;
        tests++;
        if (obs() !== {2'b00, 3'd5, 8'h06, 3'b101}) begin
            fails++; $display("FAIL ign_w1_start got %h want %h", obs(), {2'b00, 3'd5, 8'h06, 3'b101});
        end
        for (int k = 0; k < 3; k++) begin
            val_i = 1'b1; data_i = 8'(k + 7); cyc();
            tests++;
            if (W1W0b_en_o !== 2'b10 || wb_addr_o !== 3'(k)) begin
                fails++; $display("FAIL ign_w1_word%0d got en %b addr %0d want en 10 addr %0d", k, W1W0b_en_o, wb_addr_o, k);
            end
        end
`ifdef PERCEPTRON_WB_CHECKSUM_EN
        data_i = 8'h2D; cyc();
`endif
        val_i = 1'b0;
        tests++;
        if (done_o !== 1'b1) begin
            fails++; $display("FAIL ign_in_done got done %b want 1", done_o);
        end
        start_i = 1'b1; cyc(); start_i = 1'b0;
        tests++;
        if (obs() !== {2'b00, 3'd2, 8'h09, 3'b000}) begin
            fails++; $display("FAIL ign_done_start got %h want %h", obs(), {2'b00, 3'd2, 8'h09, 3'b000});
        end
        cyc();
        tests++;
        if (obs() !== {2'b00, 3'd2, 8'h09, 3'b000}) begin
            fails++; $display("FAIL ign_idle_after got %h want %h", obs(), {2'b00, 3'd2, 8'h09, 3'b000});
        end
    endtask

    task automatic test_early_valid();
        apply_reset();
        val_i = 1'b1; data_i = 8'hAA; #1;
        tests++;
        if (rdy_o !== 1'b0) begin
            fails++; $display("FAIL early_rdy got %b want 0", rdy_o);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            tests++;
            if (obs() !== 16'h0000) begin
                fails++; $display("FAIL early_idle%0d got %h want 0000", k, obs());
            end
        end
        start_i = 1'b1; cyc(); start_i = 1'b0; val_i = 1'b0;
        tests++;
        if (obs() !== {2'b00, 3'd0, 8'h00, 3'b101}) begin
            fails++; $display("FAIL early_start got %h want %h", obs(), {2'b00, 3'd0, 8'h00, 3'b101});
        end
        cyc();
        tests++;
        if (wb_data_o === 8'hAA || W1W0b_en_o !== 2'b00) begin
            fails++; $display("FAIL early_noaa got data %h en %b want data !aa en 00", wb_data_o, W1W0b_en_o);
        end
    endtask

`ifdef PERCEPTRON_WB_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] fin [0:1];
        logic       exp_err [0:1];
        fin[0] = 8'h2D; exp_err[0] = 1'b0;
        fin[1] = 8'h2C; exp_err[1] = 1'b1;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            start_i = 1'b1; cyc(); start_i = 1'b0;
            tests++;
            if (error_o !== 1'b0) begin
                fails++; $display("FAIL csum_clear%0d got %b want 0", r, error_o);
            end
            for (int k = 0; k < 9; k++) begin
                val_i = 1'b1; data_i = 8'(k + 1); cyc();
            end
            tests++;
            if (obs() !== {2'b10, 3'd2, 8'h09, 3'b101}) begin
                fails++; $display("FAIL csum_check%0d got %h want %h", r, obs(), {2'b10, 3'd2, 8'h09, 3'b101});
            end
            data_i = fin[r]; cyc(); val_i = 1'b0;
            tests++;
            if (obs() !== {2'b00, 3'd2, 8'h09, 3'b010} || error_o !== exp_err[r]) begin
                fails++; $display("FAIL csum_done%0d got %h err %b want %h err %b", r, obs(), error_o, {2'b00, 3'd2, 8'h09, 3'b010}, exp_err[r]);
            end
            cyc(); cyc();
            tests++;
            if (error_o !== exp_err[r]) begin
                fails++; $display("FAIL csum_hold%0d got %b want %b", r, error_o, exp_err[r]);
            end
        end
        start_i = 1'b1; cyc(); start_i = 1'b0;
        tests++;
        if (error_o !== 1'b0) begin
            fails++; $display("FAIL csum_restart got %b want 0", error_o);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start_i = 1'b0; val_i = 1'b0; data_i = 8'h00;
        test_reset();
        test_nominal();
        test_stall();
        test_mid_reset();
        test_ignored_start();
        test_early_valid();
`ifdef PERCEPTRON_WB_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
